// File: rtl/vx_mem_bus_sequencer.sv
// vx_mem_bus_sequencer: bridges Vortex mem_req/mem_rsp onto a single-outstanding
// generic bus port. One transaction in flight at a time; read data is returned
// with its original tag, writes complete silently, bus errors are counted.
module vx_mem_bus_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8,
    parameter int ERR_CW = 8
) (
    input  logic                VX_clk,
    input  logic                VX_reset,
    input  logic                mem_req_valid,
    input  logic                mem_req_rw,
    input  logic [DATA_W/8-1:0] mem_req_byteen,
    input  logic [ADDR_W-1:0]   mem_req_addr,
    input  logic [DATA_W-1:0]   mem_req_data,
    input  logic [TAG_W-1:0]    mem_req_tag,
    output logic                mem_req_ready,
    output logic                mem_rsp_valid,
    output logic [DATA_W-1:0]   mem_rsp_data,
    output logic [TAG_W-1:0]    mem_rsp_tag,
    input  logic                mem_rsp_ready,
    output logic                bus_ren,
    output logic                bus_wen,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_strobe,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_request_stall,
    input  logic                bus_error,
    input  logic                err_clr,
    output logic                err_sticky,
    output logic [ERR_CW-1:0]   err_count,
    output logic                seq_busy
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_done;

    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_byteen;
    logic [TAG_W-1:0]    r_tag;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_err_sticky;
    logic [ERR_CW-1:0]   r_err_count;

    assign w_accept = (r_state == S_IDLE) && mem_req_valid;
    assign w_done   = (r_state == S_BUS) && !bus_request_stall;

    // State register
    always_ff @(posedge VX_clk) begin
        if (VX_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next        = r_state;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        bus_ren       = 1'b0;
        bus_wen       = 1'b0;
        seq_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                mem_req_ready = 1'b1;
                seq_busy      = 1'b0;
                if (mem_req_valid) w_next = S_BUS;
            end
            S_BUS: begin
                bus_ren = ~r_rw;
                bus_wen = r_rw;
                // Writes finish here; reads park in RSP until Vortex takes the data.
                if (!bus_request_stall) w_next = r_rw ? S_IDLE : S_RSP;
            end
            S_RSP: begin
                mem_rsp_valid = 1'b1;
                if (mem_rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Capture the request on acceptance; holds bus outputs stable through stalls
    always_ff @(posedge VX_clk) begin
        if (VX_reset) begin
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_byteen <= '0;
            r_tag    <= '0;
        end else if (w_accept) begin
            r_rw     <= mem_req_rw;
            r_addr   <= mem_req_addr;
            r_wdata  <= mem_req_data;
            r_byteen <= mem_req_byteen;
            r_tag    <= mem_req_tag;
        end
    end

    // Read data capture; an erroring read returns zero rather than bus garbage
    always_ff @(posedge VX_clk) begin
        if (VX_reset)            r_rsp_data <= '0;
        else if (w_done && !r_rw) r_rsp_data <= bus_error ? '0 : bus_rdata;
    end

    // Error tracking; a clear wins over an error landing in the same cycle
    always_ff @(posedge VX_clk) begin
        if (VX_reset || err_clr) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (w_done && bus_error) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != {ERR_CW{1'b1}})
                r_err_count <= r_err_count + ERR_CW'(1);
        end
    end

    assign bus_addr     = r_addr;
    assign bus_wdata    = r_wdata;
    assign bus_strobe   = r_byteen;
    assign mem_rsp_data = r_rsp_data;
    assign mem_rsp_tag  = r_tag;
    assign err_sticky   = r_err_sticky;
    assign err_count    = r_err_count;

endmodule
